ifid_fetch_queue: RTL and testbench

//   Parametrised IF/ID boundary: a DEPTH-entry fetch queue plus the ID-facing output register.

---
 rtl/ifid_pkg.sv | 19 +
 rtl/ifid_fifo.sv | 75 +++++++
 rtl/ifid_fetch_queue.sv | 125 ++++++++++++
 tb/tb_ifid_fetch_queue.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ifid_pkg.sv
// Shared types for the IF/ID fetch queue: the queued fetch record and the bubble-select helper.
package ifid_pkg;

    localparam int FQ_XLEN = 32;
    localparam logic [FQ_XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0;

    typedef struct packed {
        logic [FQ_XLEN-1:0] instr;
        logic [FQ_XLEN-1:0] pcadd4;
        logic [FQ_XLEN-1:0] pc;
        logic               is_bds;
    } fetch_entry_t;

    // ID receives a bubble when a flush is being applied or no source has an instruction.
    function automatic logic is_bubble(input logic flush_sel, input logic have_entry);
        return flush_sel | ~have_entry;
    endfunction

endpackage

// File: rtl/ifid_fifo.sv
// Synchronous FIFO of fetch records; DEPTH must be a power of two so the pointers wrap naturally.
module ifid_fifo
    import ifid_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/ifid_fetch_queue.sv
// IF/ID boundary: fetch queue plus the ID-facing register carrying restart-PC, delay-slot and flush tags.
module ifid_fetch_queue
    import ifid_pkg::*;
#(
    parameter int                XLEN      = FQ_XLEN,
    parameter int                DEPTH     = 2,
    parameter logic [XLEN-1:0]   NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         if_valid,
    input  logic [XLEN-1:0]              if_instr,
    input  logic [XLEN-1:0]              if_pcadd4,
    input  logic [XLEN-1:0]              if_pc,
    input  logic                         if_is_bds,
    output logic                         if_ready,
    input  logic                         flush,
    input  logic                         id_stall,
    output logic                         id_valid,
    output logic [XLEN-1:0]              id_instruction,
    output logic [XLEN-1:0]              id_pcadd4,
    output logic [XLEN-1:0]              id_restart_pc,
    output logic                         id_is_bds,
    output logic                         id_is_flushed,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    // Handshake: IF transfers a word in any cycle where if_valid & if_ready are both high and
    // flush is low; while if_ready is low IF must hold its word and its inputs are ignored.

    fetch_entry_t if_entry, q_head, src;
    logic         q_push, q_pop, q_full, q_empty;
    logic         flush_sel, bypass;

    logic            id_valid_q,      id_valid_d;
    logic [XLEN-1:0] id_instr_q,      id_instr_d;
    logic [XLEN-1:0] id_pcadd4_q,     id_pcadd4_d;
    logic [XLEN-1:0] id_restart_pc_q, id_restart_pc_d;
    logic            id_is_bds_q,     id_is_bds_d;
    logic            id_is_flushed_q, id_is_flushed_d;
    logic            pend_flush_q,    pend_flush_d;

    assign if_entry = '{instr: if_instr, pcadd4: if_pcadd4, pc: if_pc, is_bds: if_is_bds};

    ifid_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (q_push),
        .pop   (q_pop),
        .clear (flush),
        .wdata (if_entry),
        .rdata (q_head),
        .count (count),
        .full  (q_full),
        .empty (q_empty)
    );

    always_comb begin
        flush_sel = flush | pend_flush_q;
        // An empty queue forwards IF straight into ID instead of spending a cycle in storage.
        bypass    = ~id_stall & ~flush_sel & q_empty & if_valid;
        q_push    = if_valid & ~q_full & ~flush & ~bypass;
        // A pending flush consumes the unstalled cycle, so words fetched after the flush stay queued.
        q_pop     = ~id_stall & ~q_empty & ~flush_sel;
        src       = q_empty ? if_entry : q_head;

        id_valid_d      = id_valid_q;
        id_instr_d      = id_instr_q;
        id_pcadd4_d     = id_pcadd4_q;
        id_restart_pc_d = id_restart_pc_q;
        id_is_bds_d     = id_is_bds_q;
        id_is_flushed_d = id_is_flushed_q;
        pend_flush_d    = pend_flush_q;

        if (!id_stall) begin
            id_is_flushed_d = flush_sel;
            pend_flush_d    = 1'b0;
            if (is_bubble(flush_sel, ~q_empty | if_valid)) begin
                id_valid_d  = 1'b0;
                id_instr_d  = NOP_INSTR;
                id_is_bds_d = 1'b0;
            end else begin
                id_valid_d  = 1'b1;
                id_instr_d  = src.instr;
                id_pcadd4_d = src.pcadd4;
                id_is_bds_d = src.is_bds;
                // A delay slot restarts at its branch, whose PC is already held here.
                if (!src.is_bds) begin
                    id_restart_pc_d = src.pc;
                end
            end
        end else if (flush) begin
            pend_flush_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            id_valid_q      <= 1'b0;
            id_instr_q      <= NOP_INSTR;
            id_pcadd4_q     <= '0;
            id_restart_pc_q <= '0;
            id_is_bds_q     <= 1'b0;
            id_is_flushed_q <= 1'b0;
            pend_flush_q    <= 1'b0;
        end else begin
            id_valid_q      <= id_valid_d;
            id_instr_q      <= id_instr_d;
            id_pcadd4_q     <= id_pcadd4_d;
            id_restart_pc_q <= id_restart_pc_d;
            id_is_bds_q     <= id_is_bds_d;
            id_is_flushed_q <= id_is_flushed_d;
            pend_flush_q    <= pend_flush_d;
        end
    end

    assign if_ready       = ~q_full;
    assign id_valid       = id_valid_q;
    assign id_instruction = id_instr_q;
    assign id_pcadd4      = id_pcadd4_q;
    assign id_restart_pc  = id_restart_pc_q;
    assign id_is_bds      = id_is_bds_q;
    assign id_is_flushed  = id_is_flushed_q;

endmodule

// File: tb/tb_ifid_fetch_queue.sv
// Directed bench for ifid_fetch_queue (XLEN=32, DEPTH=2) with hand-computed expectations.
module tb_ifid_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            CLK = 1'b0;
    logic            RST;
    logic            if_valid;
    logic [XLEN-1:0] if_instr, if_pcadd4, if_pc;
    logic            if_is_bds;
    logic            if_ready;
    logic            flush, id_stall;
    logic            id_valid;
    logic [XLEN-1:0] id_instruction, id_pcadd4, id_restart_pc;
    logic            id_is_bds, id_is_flushed;
    logic [1:0]      count;

    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] exp_pc_q[$];
    int              checks = 0;
    int              errors = 0;

    ifid_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(32'h0)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pcadd4      (if_pcadd4),
        .if_pc          (if_pc),
        .if_is_bds      (if_is_bds),
        .if_ready       (if_ready),
        .flush          (flush),
        .id_stall       (id_stall),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_pcadd4      (id_pcadd4),
        .id_restart_pc  (id_restart_pc),
        .id_is_bds      (id_is_bds),
        .id_is_flushed  (id_is_flushed),
        .count          (count)
    );

    // clock
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are then sampled after the next edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_if(input logic v, input logic [XLEN-1:0] instr,
                            input logic [XLEN-1:0] pc, input logic bds);
        if_valid  = v;
        if_instr  = instr;
        if_pc     = pc;
        if_pcadd4 = pc + 32'd4;
        if_is_bds = bds;
    endtask

    initial begin
        RST = 1'b1; flush = 1'b0; id_stall = 1'b0;
        drive_if(1'b0, 32'h0, 32'h0, 1'b0);

        // 1. reset
        tick(); tick();
        check_eq("rst_count",    32'(count), 32'd0);
        check_eq("rst_valid",    32'(id_valid), 32'd0);
        check_eq("rst_instr",    id_instruction, 32'h0);
        check_eq("rst_restart",  id_restart_pc, 32'h0);
        check_eq("rst_ready",    32'(if_ready), 32'd1);
        check_eq("rst_flushed",  32'(id_is_flushed), 32'd0);
        RST = 1'b0;
        tick();
        check_eq("idle_valid",   32'(id_valid), 32'd0);

        // 2. bypass into ID from an empty queue
        drive_if(1'b1, 32'h8C220004, 32'h100, 1'b0);
        tick();
        check_eq("byp_instr",    id_instruction, 32'h8C220004);
        check_eq("byp_restart",  id_restart_pc, 32'h100);
        check_eq("byp_pcadd4",   id_pcadd4, 32'h104);
        check_eq("byp_valid",    32'(id_valid), 32'd1);
        check_eq("byp_count",    32'(count), 32'd0);

        // 3. stalled ID, queue fills, third word refused
        id_stall = 1'b1;
        drive_if(1'b1, 32'hA0, 32'h300, 1'b0);
        tick();
        check_eq("fill1_count",  32'(count), 32'd1);
        drive_if(1'b1, 32'hA1, 32'h304, 1'b0);
        tick();
        check_eq("fill2_count",  32'(count), 32'd2);
        check_eq("fill2_ready",  32'(if_ready), 32'd0);
        drive_if(1'b1, 32'hA2, 32'h308, 1'b0);
        tick();
        check_eq("full_count",   32'(count), 32'd2);
        check_eq("stall_hold",   id_instruction, 32'h8C220004);
        id_stall = 1'b0;
        drive_if(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        check_eq("drain1_instr", id_instruction, 32'hA0);
        check_eq("drain1_count", 32'(count), 32'd1);
        tick();
        check_eq("drain2_instr", id_instruction, 32'hA1);
        check_eq("drain2_rpc",   id_restart_pc, 32'h304);
        check_eq("drain2_count", 32'(count), 32'd0);
        tick();
        check_eq("bub_valid",    32'(id_valid), 32'd0);
        check_eq("bub_instr",    id_instruction, 32'h0);
        check_eq("bub_pcadd4",   id_pcadd4, 32'h308);
        check_eq("bub_rpc",      id_restart_pc, 32'h304);
        check_eq("bub_flushed",  32'(id_is_flushed), 32'd0);

        // 4. branch then delay slot
        drive_if(1'b1, 32'hB0, 32'h200, 1'b0);
        tick();
        check_eq("br_rpc",       id_restart_pc, 32'h200);
        check_eq("br_bds",       32'(id_is_bds), 32'd0);
        drive_if(1'b1, 32'hB1, 32'h204, 1'b1);
        tick();
        check_eq("bds_instr",    id_instruction, 32'hB1);
        check_eq("bds_rpc",      id_restart_pc, 32'h200);
        check_eq("bds_flag",     32'(id_is_bds), 32'd1);
        check_eq("bds_pcadd4",   id_pcadd4, 32'h208);

        // 5. flush while stalled with a full queue
        id_stall = 1'b1;
        drive_if(1'b1, 32'hC0, 32'h400, 1'b0);
        tick();
        drive_if(1'b1, 32'hC1, 32'h404, 1'b0);
        tick();
        check_eq("pre_fl_count", 32'(count), 32'd2);
        flush = 1'b1;
        drive_if(1'b1, 32'hC2, 32'h408, 1'b0);
        tick();
        check_eq("fl_count",     32'(count), 32'd0);
        check_eq("fl_hold",      id_instruction, 32'hB1);
        check_eq("fl_hold_vld",  32'(id_valid), 32'd1);
        flush = 1'b0; id_stall = 1'b0;
        drive_if(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        check_eq("pf_flushed",   32'(id_is_flushed), 32'd1);
        check_eq("pf_valid",     32'(id_valid), 32'd0);
        check_eq("pf_instr",     id_instruction, 32'h0);
        check_eq("pf_rpc",       id_restart_pc, 32'h200);
        tick();
        check_eq("pf2_flushed",  32'(id_is_flushed), 32'd0);
        check_eq("pf2_count",    32'(count), 32'd0);

        // unstalled flush drops the incoming word
        flush = 1'b1;
        drive_if(1'b1, 32'hD0, 32'h600, 1'b0);
        tick();
        check_eq("uf_flushed",   32'(id_is_flushed), 32'd1);
        check_eq("uf_count",     32'(count), 32'd0);
        flush = 1'b0;
        drive_if(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        check_eq("uf2_flushed",  32'(id_is_flushed), 32'd0);

        // 6. simultaneous push/pop at count=1 and pointer wrap over 4*DEPTH words
        id_stall = 1'b1;
        drive_if(1'b1, 32'hE000_0000, 32'h500, 1'b0);
        exp_q.push_back(32'hE000_0000);
        exp_pc_q.push_back(32'h500);
        tick();
        check_eq("pp_pre_count", 32'(count), 32'd1);
        id_stall = 1'b0;
        for (int k = 1; k <= 4 * DEPTH; k++) begin
            drive_if(1'b1, 32'hE000_0000 + 32'(k), 32'h500 + 32'(4 * k), 1'b0);
            exp_q.push_back(32'hE000_0000 + 32'(k));
            exp_pc_q.push_back(32'h500 + 32'(4 * k));
            tick();
            check_eq("pp_instr",  id_instruction, exp_q.pop_front());
            check_eq("pp_rpc",    id_restart_pc, exp_pc_q.pop_front());
            check_eq("pp_count",  32'(count), 32'd1);
        end
        drive_if(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        check_eq("pp_last",      id_instruction, exp_q.pop_front());
        check_eq("pp_last_cnt",  32'(count), 32'd0);
        exp_pc_q.delete();

        // reset dominates flush and push
        RST = 1'b1; flush = 1'b1;
        drive_if(1'b1, 32'hF0, 32'h700, 1'b0);
        tick();
        check_eq("rd_count",     32'(count), 32'd0);
        check_eq("rd_valid",     32'(id_valid), 32'd0);
        check_eq("rd_flushed",   32'(id_is_flushed), 32'd0);
        check_eq("rd_rpc",       id_restart_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
